// File: rtl/fcs_frame_ctrl.sv
// rtl/fcs_frame_ctrl.sv - frame serialiser with CRC/FCS append, feeds the FCS bit counter
//
// Purpose:
//   Accepts one parallel frame per Data_Valid/Data_Ready handshake, shifts the
//   data bits out LSB-first while enabling the external bit counter, accumulates
//   a CRC over the transmitted bits, then appends the CRC MSB-first as FCS bits.
//   The counter's Cnt_done flag marks the last data bit of the frame.
//
// Ports:
//   CLK         in   1          system clock, posedge
//   RST         in   1          synchronous active-high reset
//   Data_In     in   IN_WIDTH   parallel frame, bit 0 transmitted first
//   Data_Valid  in   1          Data_In valid
//   Data_Ready  out  1          frame accepted this cycle if valid (IDLE only)
//   Cnt_En      out  1          counter enable (SHIFT only)
//   Cnt_done    in   1          counter at Data_Size-1: current bit is last data bit
//   Ser_Out     out  1          serial bit
//   Ser_Valid   out  1          Ser_Out meaningful (SHIFT and FCS)
//   Fcs_Phase   out  1          Ser_Out is an FCS bit
//   Frame_Done  out  1          one-cycle pulse after the last FCS bit

module fcs_frame_ctrl #(
    parameter int                   IN_WIDTH  = 1024,
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY      = 8'h07,
    parameter logic [CRC_WIDTH-1:0] SEED      = 8'h00
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IN_WIDTH-1:0] Data_In,
    input  logic                Data_Valid,
    output logic                Data_Ready,
    output logic                Cnt_En,
    input  logic                Cnt_done,
    output logic                Ser_Out,
    output logic                Ser_Valid,
    output logic                Fcs_Phase,
    output logic                Frame_Done
);

    // Sized so the count reaches CRC_WIDTH-1 without wrapping.
    localparam int                FCS_CW   = $clog2(CRC_WIDTH) + 1;
    localparam logic [FCS_CW-1:0] FCS_LAST = FCS_CW'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FCS   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IN_WIDTH-1:0]   shift_reg;
    logic [CRC_WIDTH-1:0]  crc;
    logic [FCS_CW-1:0]     fcs_cnt;
    logic                  crc_fb;

    // Feedback uses the bit currently on Ser_Out during SHIFT.
    assign crc_fb = crc[CRC_WIDTH-1] ^ shift_reg[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Data_Ready = 1'b0;
        Cnt_En     = 1'b0;
        Ser_Out    = 1'b0;
        Ser_Valid  = 1'b0;
        Fcs_Phase  = 1'b0;
        Frame_Done = 1'b0;
        case (state)
            IDLE: begin
                Data_Ready = 1'b1;
                if (Data_Valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Cnt_En    = 1'b1;
                Ser_Valid = 1'b1;
                Ser_Out   = shift_reg[0];
                if (Cnt_done) begin
                    state_next = FCS;
                end
            end
            FCS: begin
                Ser_Valid = 1'b1;
                Fcs_Phase = 1'b1;
                Ser_Out   = crc[CRC_WIDTH-1];
                if (fcs_cnt == FCS_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Frame_Done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
            crc       <= SEED;
            fcs_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        shift_reg <= Data_In;
                        crc       <= SEED;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    crc       <= {crc[CRC_WIDTH-2:0], 1'b0} ^ (crc_fb ? POLY : '0);
                    if (Cnt_done) begin
                        fcs_cnt <= '0;
                    end
                end
                FCS: begin
                    // CRC register doubles as the FCS shift register.
                    crc     <= crc << 1;
                    fcs_cnt <= fcs_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_frame_ctrl.sv
// tb/tb_fcs_frame_ctrl.sv - scoreboard bench for fcs_frame_ctrl with a bit counter model

module tb_fcs_frame_ctrl;

    localparam int IN_WIDTH  = 1024;
    localparam int CRC_WIDTH = 8;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [IN_WIDTH-1:0] Data_In = '0;
    logic                Data_Valid = 1'b0;
    logic                Data_Ready;
    logic                Cnt_En;
    logic                Cnt_done;
    logic                Ser_Out;
    logic                Ser_Valid;
    logic                Fcs_Phase;
    logic                Frame_Done;

    fcs_frame_ctrl #(
        .IN_WIDTH (IN_WIDTH),
        .CRC_WIDTH(CRC_WIDTH),
        .POLY     (8'h07),
        .SEED     (8'h00)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Data_In   (Data_In),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .Cnt_En    (Cnt_En),
        .Cnt_done  (Cnt_done),
        .Ser_Out   (Ser_Out),
        .Ser_Valid (Ser_Valid),
        .Fcs_Phase (Fcs_Phase),
        .Frame_Done(Frame_Done)
    );

    always #5 CLK = ~CLK;

    // Bit counter model: clears whenever not enabled.
    int          tb_size = 1;
    logic [10:0] cnt;
    always_ff @(posedge CLK) begin
        if (RST || !Cnt_En) cnt <= '0;
        else                cnt <= cnt + 11'd1;
    end
    assign Cnt_done = (cnt == 11'(tb_size - 1));

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic b;
        logic fcs;
    } bit_t;

    bit_t bit_q[$];
    int   done_q[$];
    int   n_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int en_cnt      = 0;
    bit ready_pending = 1'b0;

    function automatic logic [7:0] crc_model(input logic [63:0] d, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Monitor: pops expectations whenever the DUT presents output.
    always @(negedge CLK) begin
        bit_t e;
        int   exp_c;
        int   exp_n;
        if (ready_pending) begin
            vectors++;
            if (!(Data_Ready === 1'b1 && Frame_Done === 1'b0)) begin
                miscompares++;
                $display("FAIL ready_after_done: Data_Ready=%b Frame_Done=%b, want 1/0", Data_Ready, Frame_Done);
            end
            ready_pending = 1'b0;
        end
        if (Data_Ready) en_cnt = 0;
        if (Cnt_En) en_cnt++;
        if (Ser_Valid) begin
            vectors++;
            if (bit_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_bit: cycle %0d Ser_Out=%b with no bit expected", cyc, Ser_Out);
            end else begin
                e = bit_q.pop_front();
                if (Ser_Out !== e.b || Fcs_Phase !== e.fcs || Cnt_En !== !e.fcs || Data_Ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL serial_bit: cycle %0d got out=%b fcs=%b en=%b rdy=%b, want out=%b fcs=%b en=%b rdy=0",
                             cyc, Ser_Out, Fcs_Phase, Cnt_En, Data_Ready, e.b, e.fcs, !e.fcs);
                end
            end
        end
        if (Frame_Done) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: Frame_Done at cycle %0d with no frame pending", cyc);
            end else begin
                exp_c = done_q.pop_front();
                exp_n = n_q.pop_front();
                if (cyc != exp_c || en_cnt != exp_n) begin
                    miscompares++;
                    $display("FAIL frame_done: cycle %0d cnt_en_cycles %0d, want cycle %0d cnt_en_cycles %0d",
                             cyc, en_cnt, exp_c, exp_n);
                end
                ready_pending = 1'b1;
            end
        end
    end

    // Issue a frame of n bits; abort_at>0 asserts RST in that SHIFT cycle.
    task automatic issue(input logic [63:0] d, input int n, input logic [7:0] crc_exp,
                         input bit toggle, input int abort_at);
        bit_t e;
        int   k;
        int   t;
        for (int i = 0; i < n; i++) begin
            e.b = d[i]; e.fcs = 1'b0; bit_q.push_back(e);
        end
        for (int j = CRC_WIDTH - 1; j >= 0; j--) begin
            e.b = crc_exp[j]; e.fcs = 1'b1; bit_q.push_back(e);
        end
        @(negedge CLK);
        tb_size    = n;
        Data_In    = '0;
        Data_In[63:0] = d;
        Data_Valid = 1'b1;
        k = 0;
        while (!Data_Ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        vectors++;
        if (!Data_Ready) begin
            miscompares++;
            $display("FAIL handshake_timeout: Data_Ready=%b after %0d cycles, want 1", Data_Ready, k);
        end
        t = cyc;
        done_q.push_back(t + n + CRC_WIDTH + 1);
        n_q.push_back(n);
        if (abort_at > 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            repeat (abort_at - 1) @(negedge CLK);
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            vectors++;
            if (Ser_Valid !== 1'b0 || Data_Ready !== 1'b1 || Frame_Done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_reset: Ser_Valid=%b Data_Ready=%b Frame_Done=%b, want 0/1/0",
                         Ser_Valid, Data_Ready, Frame_Done);
            end
            #1;
            bit_q.delete();
            done_q.delete();
            n_q.delete();
            repeat (20) @(negedge CLK);
        end else begin
            if (toggle) begin
                for (int c = 0; c < n + CRC_WIDTH; c++) begin
                    @(negedge CLK);
                    Data_Valid = 1'($urandom_range(0, 1));
                    Data_In[31:0]  = $urandom;
                    Data_In[95:64] = $urandom;
                end
                @(negedge CLK);
                Data_Valid = 1'b0;
            end else begin
                @(negedge CLK);
                Data_Valid = 1'b0;
            end
            k = 0;
            while ((bit_q.size() != 0 || done_q.size() != 0) && k < 2000) begin
                @(negedge CLK);
                k++;
            end
            vectors++;
            if (bit_q.size() != 0 || done_q.size() != 0) begin
                miscompares++;
                $display("FAIL frame_timeout: %0d bits and %0d done pulses outstanding, want 0/0",
                         bit_q.size(), done_q.size());
            end
            repeat (3) @(negedge CLK);
        end
    endtask

    initial begin
        // Reset held with Data_Valid high.
        RST        = 1'b1;
        Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (Data_Ready !== 1'b1 || Cnt_En !== 1'b0 || Ser_Valid !== 1'b0 ||
                Frame_Done !== 1'b0 || Fcs_Phase !== 1'b0 || Ser_Out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: rdy=%b en=%b sv=%b fd=%b fcs=%b so=%b, want 1/0/0/0/0/0",
                         Data_Ready, Cnt_En, Ser_Valid, Frame_Done, Fcs_Phase, Ser_Out);
            end
        end
        Data_Valid = 1'b0;
        RST        = 1'b0;
        repeat (2) @(negedge CLK);

        // 1-bit frame, data 1: CRC 0x07.
        issue(64'h1, 1, 8'h07, 1'b0, 0);
        // 64 zero bits: CRC 0.
        issue(64'h0, 64, 8'h00, 1'b0, 0);
        // 0xA5 in a 64-bit frame: data bits 1,0,1,0,0,1,0,1 first.
        issue(64'hA5, 64, crc_model(64'hA5, 64), 1'b0, 0);
        // Data_Valid/Data_In toggled while the frame is in flight.
        issue(64'h0123_4567_89AB_CDEF, 64, crc_model(64'h0123_4567_89AB_CDEF, 64), 1'b1, 0);
        // Reset in the 20th SHIFT cycle, then a normal frame.
        issue(64'hFFFF_0000_FFFF_0000, 64, crc_model(64'hFFFF_0000_FFFF_0000, 64), 1'b0, 20);
        issue(64'h1FFF, 13, crc_model(64'h1FFF, 13), 1'b0, 0);
        // 2-bit frame.
        issue(64'h2, 2, crc_model(64'h2, 2), 1'b0, 0);

        vectors++;
        if (bit_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain: %0d bits %0d done outstanding, want 0/0", bit_q.size(), done_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
